// File: rtl/learn_commit_if.sv
// Learned-clause commit bus: literal stream in, CIT write port and backjump report out.
interface learn_commit_if #(
    parameter int LW = 4,
    parameter int CW = 4
);
    logic          Start;
    logic [LW-1:0] CurDecLevel;
    logic          LC_valid;
    logic          LC_ready;
    logic [LW:0]   LC_LID;
    logic [LW-1:0] LC_Declevel;
    logic          LC_UIP;
    logic          LC_last;
    logic          CIT_wrEn;
    logic [CW-1:0] CIT_wrCID;
    logic [LW:0]   CIT_wrLID;
    logic          CIT_wrLast;
    logic          BJ_valid;
    logic [LW-1:0] BJ_level;
    logic [LW:0]   BJ_LID;
    logic [CW-1:0] BJ_CID;
    logic          Done;
    logic          Err;

    modport master (
        output Start, CurDecLevel, LC_valid, LC_LID, LC_Declevel, LC_UIP, LC_last,
        input  LC_ready, CIT_wrEn, CIT_wrCID, CIT_wrLID, CIT_wrLast,
        input  BJ_valid, BJ_level, BJ_LID, BJ_CID, Done, Err
    );

    modport slave (
        input  Start, CurDecLevel, LC_valid, LC_LID, LC_Declevel, LC_UIP, LC_last,
        output LC_ready, CIT_wrEn, CIT_wrCID, CIT_wrLID, CIT_wrLast,
        output BJ_valid, BJ_level, BJ_LID, BJ_CID, Done, Err
    );
endinterface

// File: rtl/learn_commit.sv
// Buffers a learned clause, writes it UIP-first into the CIT learned region and reports the backjump level.
// LEARN_DEDUP_EN: drop repeated literals and abort on a variable seen with both polarities.
module learn_commit #(
    parameter int CLAUSES       = 16,
    parameter int LITERALS      = 16,
    parameter int MAX_LEN       = 8,
    parameter int FIRST_LEARNED = 8
) (
    input  logic          Clk_i,
    input  logic          Reset_i,
    learn_commit_if.slave bus
);
    localparam int LW = $clog2(LITERALS);
    localparam int CW = $clog2(CLAUSES);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int NW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] FP_FIRST = CW'(FIRST_LEARNED);
    localparam logic [CW-1:0] FP_LAST  = CW'(CLAUSES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, REPORT} state_t;
    state_t state_q, state_d;

    logic [LW:0]   buf_q [MAX_LEN];
    logic [NW-1:0] cnt_q, idx_q;
    logic [LW-1:0] maxlvl_q, cdl_q;
    logic [LW:0]   uip_q;
    logic          uip_seen_q, ovf_q, err_q;
    logic [CW-1:0] fp_q;
    logic [LW-1:0] bj_level_q;
    logic [LW:0]   bj_lid_q;
    logic [CW-1:0] bj_cid_q;

    logic          accept, full, dup, clash;
    logic          store_uip, store_lit, ovf_set, abort, wr_last;
    logic [LW-1:0] err_level;
    logic [AW-1:0] rd_ptr;
    logic [LW:0]   wr_lid;

    assign accept = (state_q == COLLECT) && bus.LC_valid;
    assign full   = (int'(cnt_q) + int'(uip_seen_q)) >= MAX_LEN;

`ifdef LEARN_DEDUP_EN
    always_comb begin
        dup   = 1'b0;
        clash = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(cnt_q) && buf_q[i][LW-1:0] == bus.LC_LID[LW-1:0]) begin
                if (buf_q[i][LW] == bus.LC_LID[LW]) dup = 1'b1;
                else                                clash = 1'b1;
            end
        end
        if (uip_seen_q && uip_q[LW-1:0] == bus.LC_LID[LW-1:0]) begin
            if (uip_q[LW] == bus.LC_LID[LW]) dup = 1'b1;
            else                             clash = 1'b1;
        end
    end
`else
    assign dup   = 1'b0;
    assign clash = 1'b0;
`endif

    // After an overflow every beat is consumed but nothing more is stored.
    assign store_uip = accept && bus.LC_UIP && !ovf_q && !(full && !uip_seen_q);
    assign store_lit = accept && !bus.LC_UIP && !ovf_q && !clash && !dup && !full;
    assign ovf_set   = accept && !ovf_q &&
                       ((bus.LC_UIP && full && !uip_seen_q) ||
                        (!bus.LC_UIP && (clash || (!dup && full))));
    assign abort     = ovf_q || ovf_set || !(uip_seen_q || store_uip);

    assign err_level = (cdl_q == '0) ? '0 : cdl_q - LW'(1);
    assign wr_last   = (idx_q == cnt_q);
    assign rd_ptr    = AW'(idx_q - NW'(1));
    assign wr_lid    = (idx_q == '0) ? uip_q : buf_q[rd_ptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = COLLECT;
            COLLECT: if (accept && bus.LC_last) state_d = abort ? REPORT : WRITE;
            WRITE:   if (wr_last) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (store_lit) buf_q[cnt_q[AW-1:0]] <= bus.LC_LID;
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            maxlvl_q   <= '0;
            cdl_q      <= '0;
            uip_q      <= '0;
            uip_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            fp_q       <= FP_FIRST;
            bj_level_q <= '0;
            bj_lid_q   <= '0;
            bj_cid_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.Start) begin
                    cdl_q      <= bus.CurDecLevel;
                    cnt_q      <= '0;
                    idx_q      <= '0;
                    maxlvl_q   <= '0;
                    uip_seen_q <= 1'b0;
                    ovf_q      <= 1'b0;
                    err_q      <= 1'b0;
                end
                COLLECT: begin
                    if (store_uip) begin
                        uip_q      <= bus.LC_LID;
                        uip_seen_q <= 1'b1;
                    end
                    if (store_lit) begin
                        cnt_q <= cnt_q + NW'(1);
                        if (bus.LC_Declevel > maxlvl_q) maxlvl_q <= bus.LC_Declevel;
                    end
                    if (ovf_set) ovf_q <= 1'b1;
                    if (accept && bus.LC_last && abort) begin
                        err_q      <= 1'b1;
                        bj_level_q <= err_level;
                        bj_lid_q   <= store_uip ? bus.LC_LID : uip_q;
                        bj_cid_q   <= fp_q;
                    end
                end
                WRITE: begin
                    idx_q <= idx_q + NW'(1);
                    if (wr_last) begin
                        bj_level_q <= maxlvl_q;
                        bj_lid_q   <= uip_q;
                        bj_cid_q   <= fp_q;
                    end
                end
                REPORT: if (!err_q) fp_q <= (fp_q == FP_LAST) ? FP_FIRST : fp_q + CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.LC_ready   = (state_q == COLLECT);
    assign bus.CIT_wrEn   = (state_q == WRITE);
    assign bus.CIT_wrCID  = (state_q == WRITE) ? fp_q : '0;
    assign bus.CIT_wrLID  = (state_q == WRITE) ? wr_lid : '0;
    assign bus.CIT_wrLast = (state_q == WRITE) && wr_last;
    assign bus.BJ_valid   = (state_q == REPORT);
    assign bus.Done       = (state_q == REPORT);
    assign bus.BJ_level   = bj_level_q;
    assign bus.BJ_LID     = bj_lid_q;
    assign bus.BJ_CID     = bj_cid_q;
    assign bus.Err        = err_q;
endmodule

// File: tb/tb_learn_commit.sv
// Bench for learn_commit: directed clauses plus randomized clauses against a queue-based reference model.
module tb_learn_commit;
    localparam int LW = 4;
    localparam int CW = 4;
    localparam int MAX_LEN = 8;
    localparam int FIRST = 8;
    localparam int CLAUSES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    learn_commit_if #(.LW(LW), .CW(CW)) bus ();

    learn_commit #(
        .CLAUSES(CLAUSES), .LITERALS(16), .MAX_LEN(MAX_LEN), .FIRST_LEARNED(FIRST)
    ) dut (
        .Clk_i  (clk),
        .Reset_i(rst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [LW:0]   q_lid[$];
    logic [LW-1:0] q_lvl[$];
    bit            q_uip[$];

    logic [LW:0]   e_wr[$];
    bit            e_err;
    logic [LW-1:0] e_level;
    logic [LW:0]   e_uip;
    logic [CW-1:0] e_cid;
    logic [CW-1:0] m_fp;

    logic [LW:0]   o_lid[$];
    logic [CW-1:0] o_cid[$];
    bit            o_last[$];
    logic [LW-1:0] o_level;
    logic [CW-1:0] o_bjcid;
    bit            o_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void clear_beats();
        q_lid.delete();
        q_lvl.delete();
        q_uip.delete();
    endfunction

    function automatic void add_beat(input bit pol, input int vid, input int lvl, input bit uip);
        q_lid.push_back({pol, vid[LW-1:0]});
        q_lvl.push_back(lvl[LW-1:0]);
        q_uip.push_back(uip);
    endfunction

    function automatic void gen_random(input int len, input int uippos);
        for (int i = 0; i < len; i++)
            add_beat(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), i == uippos);
    endfunction

    // Reference: walk the beat list, keep the literals that fit, then derive writes and report.
    task automatic model_clause(input logic [LW-1:0] cdl);
        logic [LW:0] kept[$];
        bit have_uip, bad, skip, opp;
        int maxl;
        have_uip = 0; bad = 0; maxl = 0; e_uip = '0;
        foreach (q_lid[i]) begin
            if (bad) continue;
            if (q_uip[i]) begin
                if (!have_uip && kept.size() >= MAX_LEN) bad = 1;
                else begin have_uip = 1; e_uip = q_lid[i]; end
            end else begin
                skip = 0; opp = 0;
`ifdef LEARN_DEDUP_EN
                foreach (kept[j])
                    if (kept[j][LW-1:0] == q_lid[i][LW-1:0]) begin
                        if (kept[j][LW] == q_lid[i][LW]) skip = 1; else opp = 1;
                    end
                if (have_uip && e_uip[LW-1:0] == q_lid[i][LW-1:0]) begin
                    if (e_uip[LW] == q_lid[i][LW]) skip = 1; else opp = 1;
                end
`endif
                if (opp) bad = 1;
                else if (!skip) begin
                    if (kept.size() + int'(have_uip) >= MAX_LEN) bad = 1;
                    else begin
                        kept.push_back(q_lid[i]);
                        if (int'(q_lvl[i]) > maxl) maxl = int'(q_lvl[i]);
                    end
                end
            end
        end
        e_err = bad || !have_uip;
        e_wr.delete();
        if (!e_err) begin
            e_wr.push_back(e_uip);
            foreach (kept[j]) e_wr.push_back(kept[j]);
        end
        e_level = e_err ? ((cdl == '0) ? '0 : cdl - LW'(1)) : LW'(maxl);
        e_cid = m_fp;
        if (!e_err) m_fp = (m_fp == CW'(CLAUSES - 1)) ? CW'(FIRST) : m_fp + CW'(1);
    endtask

    task automatic chk_zero(input string tag);
        check(tag, {bus.LC_ready, bus.CIT_wrEn, bus.CIT_wrCID, bus.CIT_wrLID, bus.CIT_wrLast,
                    bus.BJ_valid, bus.BJ_level, bus.BJ_LID, bus.BJ_CID, bus.Done, bus.Err}, 32'd0);
    endtask

    task automatic do_reset();
        bus.Start = 0; bus.CurDecLevel = '0; bus.LC_valid = 0; bus.LC_LID = '0;
        bus.LC_Declevel = '0; bus.LC_UIP = 0; bus.LC_last = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs");
        rst = 0;
        m_fp = CW'(FIRST);
    endtask

    task automatic run_clause(input logic [LW-1:0] cdl, input bit gaps, input bit start_mid);
        int n;
        int lat;
        bit done;
        model_clause(cdl);
        o_lid.delete(); o_cid.delete(); o_last.delete();
        lat = 0;
        @(negedge clk); bus.Start = 1; bus.CurDecLevel = cdl;
        @(negedge clk); bus.Start = 0; bus.CurDecLevel = ~cdl;
        n = q_lid.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin bus.LC_valid = 0; @(negedge clk); end
            if (i == 0) check("ready_in_collect", 32'(bus.LC_ready), 32'd1);
            bus.LC_valid = 1; bus.LC_LID = q_lid[i]; bus.LC_Declevel = q_lvl[i];
            bus.LC_UIP = q_uip[i]; bus.LC_last = (i == n - 1);
            bus.Start = start_mid && (i == 1);
            @(negedge clk);
        end
        bus.LC_valid = 0; bus.LC_last = 0; bus.LC_UIP = 0; bus.Start = 0;
        done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (bus.CIT_wrEn) begin
                o_lid.push_back(bus.CIT_wrLID);
                o_cid.push_back(bus.CIT_wrCID);
                o_last.push_back(bus.CIT_wrLast);
            end
            if (bus.Done) begin
                done = 1; lat = k;
                o_level = bus.BJ_level; o_bjcid = bus.BJ_CID; o_err = bus.Err;
                check("bj_valid_with_done", 32'(bus.BJ_valid), 32'd1);
                if (!e_err) check("bj_lid", 32'(bus.BJ_LID), 32'(e_uip));
            end else @(negedge clk);
        end
        check("done_seen", 32'(done), 32'd1);
        if (done) begin
            check("err", 32'(o_err), 32'(e_err));
            check("latency", lat, e_err ? 1 : e_wr.size() + 1);
            check("num_writes", o_lid.size(), e_wr.size());
            for (int i = 0; i < o_lid.size() && i < e_wr.size(); i++) begin
                check("wr_lid", 32'(o_lid[i]), 32'(e_wr[i]));
                check("wr_cid", 32'(o_cid[i]), 32'(e_cid));
                check("wr_last", 32'(o_last[i]), 32'(i == e_wr.size() - 1));
            end
            check("bj_level", 32'(o_level), 32'(e_level));
            check("bj_cid", 32'(o_bjcid), 32'(e_cid));
            @(negedge clk);
            check("bj_level_hold", 32'(bus.BJ_level), 32'(e_level));
            check("bj_valid_pulse", 32'(bus.BJ_valid), 32'd0);
            check("err_sticky", 32'(bus.Err), 32'(e_err));
        end
    endtask

    initial begin
        do_reset();

        // Three-literal clause, UIP second.
        clear_beats();
        add_beat(0, 3, 2, 0); add_beat(1, 7, 4, 1); add_beat(0, 9, 3, 0);
        run_clause(4'd4, 0, 0);
        check("basic_level", 32'(o_level), 32'd3);
        check("basic_cid", 32'(o_bjcid), 32'd8);
        check("basic_nwr", o_lid.size(), 3);

        do_reset();
        clear_beats();
        add_beat(1, 5, 4, 1);
        run_clause(4'd4, 0, 0);
        check("unit_level", 32'(o_level), 32'd0);
        check("unit_cid", 32'(o_bjcid), 32'd8);

        // Overflow with a stray Start mid-collect that must not re-latch the level.
        do_reset();
        clear_beats();
        gen_random(10, 1);
        run_clause(4'd6, 0, 1);
        check("ovf_err", 32'(o_err), 32'd1);
        check("ovf_level", 32'(o_level), 32'd5);
        check("ovf_nwr", o_lid.size(), 0);
        clear_beats();
        add_beat(0, 2, 1, 0); add_beat(1, 4, 2, 1);
        run_clause(4'd3, 1, 0);
        check("ovf_fp_unchanged", 32'(o_bjcid), 32'd8);

        do_reset();
        for (int c = 0; c < 9; c++) begin
            clear_beats();
            begin
                int len;
                len = int'($urandom_range(1, 4));
                gen_random(len, int'($urandom_range(0, len - 1)));
            end
            run_clause(4'($urandom_range(0, 15)), 1, 0);
            check("wrap_cid", 32'(o_bjcid), (c < 8) ? 32'(8 + c) : 32'd8);
        end

        // Reset two beats into COLLECT.
        clear_beats();
        @(negedge clk); bus.Start = 1; bus.CurDecLevel = 4'd5;
        @(negedge clk); bus.Start = 0; bus.LC_valid = 1; bus.LC_LID = 5'h03; bus.LC_UIP = 0;
        @(negedge clk); bus.LC_LID = 5'h14; bus.LC_UIP = 1;
        @(negedge clk); rst = 1; bus.LC_valid = 0; bus.LC_UIP = 0;
        @(negedge clk);
        chk_zero("reset_mid_collect");
        rst = 0;
        m_fp = CW'(FIRST);
        add_beat(0, 2, 1, 0); add_beat(1, 6, 3, 1);
        run_clause(4'd3, 0, 0);
        check("post_reset_cid", 32'(o_bjcid), 32'd8);
        check("post_reset_level", 32'(o_level), 32'd1);

`ifdef LEARN_DEDUP_EN
        clear_beats();
        add_beat(0, 3, 1, 0); add_beat(0, 3, 1, 0); add_beat(1, 7, 2, 1);
        run_clause(4'd4, 0, 0);
        check("dedup_nwr", o_lid.size(), 2);
        clear_beats();
        add_beat(0, 3, 1, 0); add_beat(1, 3, 1, 0);
        run_clause(4'd4, 0, 0);
        check("dedup_clash_err", 32'(o_err), 32'd1);
`endif

        for (int c = 0; c < 40; c++) begin
            int len, up;
            // Beats offered outside COLLECT must be ignored.
            @(negedge clk); bus.LC_valid = 1; bus.LC_UIP = 1; bus.LC_last = 1;
            @(negedge clk);
            check("stray_ready", 32'(bus.LC_ready), 32'd0);
            check("stray_wren", 32'(bus.CIT_wrEn), 32'd0);
            bus.LC_valid = 0; bus.LC_UIP = 0; bus.LC_last = 0;
            clear_beats();
            len = int'($urandom_range(1, 11));
            up  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, len - 1));
            gen_random(len, up);
            run_clause(4'($urandom_range(0, 15)), 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/learn_commit.md
Name: learn_commit

Overview:
- Downstream of the conflict-analysis stage in the CDCL datapath.
- Consumes the learned-clause literal stream that conflict analysis emits, one literal per beat.
- Computes the non-chronological backjump level and writes the clause into the learned region of the clause information table (CIT), UIP literal first.
- Reports the backjump level and asserting literal to the backtrack/BCP control.

Parameters:
- clauses, 16, CIT depth; CID width = $clog2(clauses).
- literals, 16, variable count; VID/level width LW = $clog2(literals); LID = {polarity, VID}, LW+1 bits.
- max_len, 8, learned-clause literal capacity.
- first_learned, 8, first CID of the learned-clause region; region spans first_learned..clauses-1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle pulse; a new learned clause follows.
- CurDecLevel  in  LW  current decision level, sampled on Start.
- LC_valid  in  1  literal beat valid.
- LC_ready  out  1  block accepts a beat.
- LC_LID  in  LW+1  literal {polarity, VID}.
- LC_Declevel  in  LW  decision level of the literal's variable.
- LC_UIP  in  1  beat is the asserting (UIP) literal.
- LC_last  in  1  final beat of the clause.
- CIT_wrEn  out  1  CIT write strobe.
- CIT_wrCID  out  CID  clause slot being written.
- CIT_wrLID  out  LW+1  literal written.
- CIT_wrLast  out  1  final literal of the clause.
- BJ_valid  out  1  one-cycle backjump report.
- BJ_level  out  LW  backjump level.
- BJ_LID  out  LW+1  asserting literal.
- BJ_CID  out  CID  CID of the committed clause.
- Done  out  1  one-cycle pulse, coincident with BJ_valid.
- Err  out  1  sticky; set on overflow or missing UIP, cleared by the next Start.

Behaviour:
- Reset values: all outputs 0. Free pointer = first_learned. State = IDLE. Buffer empty.
- States: IDLE, COLLECT, WRITE, REPORT.
- IDLE:
  - LC_ready=0.
  - Start -> COLLECT on the next cycle.
  - On Start: latch CurDecLevel; clear count, max level, UIP-seen and Err.
- COLLECT:
  - LC_ready=1; one beat is accepted per cycle when LC_valid=1.
  - UIP beat: stored in the UIP register; it is not counted toward max level.
  - Non-UIP beat: appended to the buffer in arrival order; maxlvl = max(maxlvl, LC_Declevel).
  - Total stored literals (UIP included) beyond max_len: set the overflow flag and discard further beats, but keep consuming until LC_last.
  - A beat with LC_last=1 is accepted, then the FSM moves to WRITE. If overflow was flagged or no UIP was seen, it moves straight to REPORT with Err=1.
- WRITE:
  - One CIT write per cycle, CIT_wrCID = free pointer.
  - Beat 0 is the UIP literal; the buffered literals follow in arrival order.
  - CIT_wrLast=1 on the final write; that cycle also advances to REPORT.
  - A clause of N literals takes exactly N WRITE cycles.
- REPORT (1 cycle):
  - Done=1, BJ_valid=1, BJ_LID = UIP literal, BJ_CID = slot written.
  - BJ_level = maxlvl; 0 for a unit clause.
  - Error case: BJ_level = CurDecLevel-1 (0 if CurDecLevel=0), CIT_wrEn never asserted, free pointer unchanged.
  - Success case: free pointer += 1; from clauses-1 it wraps to first_learned, overwriting the oldest learned clause.
  - Then -> IDLE.
- Latency: last beat accepted at cycle t -> first CIT write at t+1 -> Done at t+N+1.
- Start outside IDLE is ignored.
- LC_valid while LC_ready=0 is ignored; beats are never stalled mid-COLLECT.
- Reset mid-operation: return to IDLE, drop the buffer, no further CIT writes. The free pointer resets to first_learned.
- BJ_level, BJ_LID and BJ_CID hold their values after REPORT until the next REPORT.

Optional Feature:
- Macro: LEARN_DEDUP_EN.
- Defined: each non-UIP beat is compared against all buffered VIDs and the UIP VID.
  - Same VID, same polarity: the beat is dropped and not counted.
  - Same VID, opposite polarity: Err is set and the clause is aborted as on overflow.
- Undefined: no comparison; every beat is stored; buffer logic is only the append path.

Test Plan:
- Start, CurDecLevel=4; beats {0,3} lvl2, {1,7} lvl4 UIP, {0,9} lvl3 last -> CIT writes CID 8: {1,7},{0,3},{0,9}, CIT_wrLast on the 3rd; Done with BJ_level=3, BJ_LID={1,7}, BJ_CID=8; free pointer=9.
- Unit clause: single beat {1,5} lvl4, UIP=1, LC_last=1 -> one write to CID 8 with CIT_wrLast=1; BJ_level=0.
- Overflow, max_len=8: 10 beats, UIP at beat 1, CurDecLevel=6 -> no CIT_wrEn; Err=1; BJ_level=5; free pointer unchanged.
- Wrap: commit 8 clauses starting at CID 8 -> CIDs 8..15 written; the 9th clause is written to CID 8.
- Reset asserted two beats into COLLECT -> all outputs 0 next cycle; a subsequent Start plus a 2-literal clause commits to CID 8.
- LEARN_DEDUP_EN defined: beats {0,3},{0,3},{1,7} UIP last -> 2 writes ({1,7},{0,3}). Beats {0,3},{1,3} -> Err=1, no writes.
